// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: gray/binary conversion and the read-side output FSM states.
// Functions work on a fixed 32-bit carrier; callers zero-extend and slice to their pointer width.
package fifo_pkg;

  localparam int unsigned MaxPtrW = 32;

  typedef enum logic {S_EMPTY, S_VALID} rd_state_t;

  function automatic logic [MaxPtrW-1:0] bin2gray(input logic [MaxPtrW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits must be zero; each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [MaxPtrW-1:0] gray2bin(input logic [MaxPtrW-1:0] g);
    logic [MaxPtrW-1:0] b;
    b[MaxPtrW-1] = g[MaxPtrW-1];
    for (int i = MaxPtrW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/read_ptr_ctrl_if.sv
// Read-side bus of the async FIFO: consumer handshake, synchronised write pointer,
// RAM read port and status flags.
interface read_ptr_ctrl_if #(
  parameter int unsigned ADDRSIZE = 9
);
  logic                rinc;
  logic                rready;
  logic                uf_clr;
  logic [ADDRSIZE:0]   wptr_sync;
  logic [ADDRSIZE-1:0] raddr;
  logic                rren;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rcount;
  logic                rvalid;
  logic                runderflow;

  modport master (
    output rinc, rready, uf_clr, wptr_sync,
    input  raddr, rren, rptr, rempty, raempty, rcount, rvalid, runderflow
  );

  modport slave (
    input  rinc, rready, uf_clr, wptr_sync,
    output raddr, rren, rptr, rempty, raempty, rcount, rvalid, runderflow
  );
endinterface

// File: rtl/fifo_fwft_stage.sv
// First-word-fall-through output stage: tracks whether the RAM output register holds
// an unconsumed head word.
module fifo_fwft_stage
  import fifo_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fetch_i,
  input  logic rready_i,
  output logic rvalid_o
);

  rd_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (fetch_i) state_d = S_VALID;
      // A fetch alongside rready refills the head word: back-to-back streaming.
      S_VALID: if (rready_i && !fetch_i) state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  assign rvalid_o = (state_q == S_VALID);

endmodule

// File: rtl/read_ptr_ctrl.sv
// Async FIFO read-side controller: gray read pointer, empty/almost-empty flags, fill count,
// sticky underflow and optional first-word-fall-through output stage.
module read_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = 9,
  parameter int unsigned AE_THRESH = 4,
  parameter bit          FWFT      = 1'b0
) (
  input logic            rclk,
  input logic            r_rst_n,
  read_ptr_ctrl_if.slave bus
);

  localparam int unsigned PtrW = ADDRSIZE + 1;

  logic [PtrW-1:0]    rbin_q, rbin_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;
  logic [PtrW-1:0]    rcount_q, rcount_d;
  logic               rempty_q, rempty_d;
  logic               raempty_q, raempty_d;
  logic               uf_q, uf_d;
  logic               fetch;
  logic               rvalid;
  logic [PtrW-1:0]    wbin;
  logic [MaxPtrW-1:0] wbin_w, rgray_w;
  logic               unused_hi;

  if (FWFT) begin : g_fwft
    fifo_fwft_stage u_fwft_stage (
      .clk_i    (rclk),
      .rst_ni   (r_rst_n),
      .fetch_i  (fetch),
      .rready_i (bus.rready),
      .rvalid_o (rvalid)
    );
    assign fetch = !rempty_q && (!rvalid || bus.rready);
  end else begin : g_std
    assign rvalid = 1'b0;
    assign fetch  = bus.rinc && !rempty_q;
  end

  always_comb begin
    wbin_w    = gray2bin(MaxPtrW'(bus.wptr_sync));
    wbin      = wbin_w[PtrW-1:0];
    rbin_d    = rbin_q + PtrW'(fetch);
    rgray_w   = bin2gray(MaxPtrW'(rbin_d));
    rptr_d    = rgray_w[PtrW-1:0];
    rempty_d  = (rptr_d == bus.wptr_sync);
    // Modular subtraction keeps the count right across pointer wrap.
    rcount_d  = wbin - rbin_d;
    raempty_d = (MaxPtrW'(rcount_d) <= AE_THRESH);
    uf_d      = uf_q;
    if (!FWFT && bus.rinc && rempty_q) uf_d = 1'b1;
    else if (bus.uf_clr)               uf_d = 1'b0;
  end

  assign unused_hi = ^{wbin_w[MaxPtrW-1:PtrW], rgray_w[MaxPtrW-1:PtrW]};

  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rcount_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      uf_q      <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rcount_q  <= rcount_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      uf_q      <= uf_d;
    end
  end

  assign bus.raddr      = rbin_q[ADDRSIZE-1:0];
  assign bus.rren       = fetch;
  assign bus.rptr       = rptr_q;
  assign bus.rempty     = rempty_q;
  assign bus.raempty    = raempty_q;
  assign bus.rcount     = rcount_q;
  assign bus.rvalid     = rvalid;
  assign bus.runderflow = uf_q;

endmodule
